dmem_arbiter: RTL

- Shares the single-port data memory between two requesters:
  - the pipeline MEM stage (primary);
  - a debug/loader port using a valid/ready handshake (secondary).
- Sits between the MEM stage and data_mem. It drives the memory address, write data and write enable. It asserts a stall to the pipeline whenever the debug port owns the memory in a cycle where MEM also needs it.
- Supports locked debug bursts and one-cycle-latency registered debug read returns.

---
 rtl/dmem_arbiter_pkg.sv | 8 +
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arb_starve_cnt.sv | 36 +++
 rtl/dmem_arbiter.sv | 83 ++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared widths and defaults for the data-memory arbiter between the MEM stage
// and the debug/loader port.
package dmem_arbiter_pkg;
  localparam int DMEM_ADDR_W       = 32;
  localparam int DMEM_DATA_W       = 32;
  localparam int DMEM_STARVE_LIMIT = 8;
  localparam int STARVE_CNT_W      = 8;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of pipeline, debug and data_mem signals around dmem_arbiter.
// "slave" is the arbiter's view; "master" is the view of the surrounding system.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
);
    logic              i_pipe_Req;
    logic              i_pipe_WrEn;
    logic [ADDR_W-1:0] i_pipe_Addr;
    logic [DATA_W-1:0] i_pipe_WrData;
    logic [DATA_W-1:0] o_pipe_RdData;
    logic              o_pipe_Stall;

    // Debug beat completes on a cycle where i_dbg_Valid && o_dbg_Ready; the
    // requester holds Addr/WrData/WrEn/Lock stable until then. Ready may
    // depend combinationally on Valid, never the reverse.
    logic              i_dbg_Valid;
    logic              i_dbg_WrEn;
    logic              i_dbg_Lock;
    logic [ADDR_W-1:0] i_dbg_Addr;
    logic [DATA_W-1:0] i_dbg_WrData;
    logic              o_dbg_Ready;
    logic              o_dbg_RdValid;
    logic [DATA_W-1:0] o_dbg_RdData;
    logic              o_dbg_Locked;

    logic [ADDR_W-1:0] o_mem_Addr;
    logic [DATA_W-1:0] o_mem_DataIn;
    logic              o_mem_WrEn;
    logic [DATA_W-1:0] i_mem_DataOut;

    modport slave (
        input  i_pipe_Req, i_pipe_WrEn, i_pipe_Addr, i_pipe_WrData,
        output o_pipe_RdData, o_pipe_Stall,
        input  i_dbg_Valid, i_dbg_WrEn, i_dbg_Lock, i_dbg_Addr, i_dbg_WrData,
        output o_dbg_Ready, o_dbg_RdValid, o_dbg_RdData, o_dbg_Locked,
        output o_mem_Addr, o_mem_DataIn, o_mem_WrEn,
        input  i_mem_DataOut
    );

    modport master (
        output i_pipe_Req, i_pipe_WrEn, i_pipe_Addr, i_pipe_WrData,
        input  o_pipe_RdData, o_pipe_Stall,
        output i_dbg_Valid, i_dbg_WrEn, i_dbg_Lock, i_dbg_Addr, i_dbg_WrData,
        input  o_dbg_Ready, o_dbg_RdValid, o_dbg_RdData, o_dbg_Locked,
        input  o_mem_Addr, o_mem_DataIn, o_mem_WrEn,
        output i_mem_DataOut
    );
endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of denied debug cycles; raises force_dbg at STARVE_LIMIT.
// Compiled only when LIGHT_DMEM_ARB_FAIRNESS_EN is defined.
`ifdef LIGHT_DMEM_ARB_FAIRNESS_EN
module dmem_arb_starve_cnt
  import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic dbg_valid,
    input  logic dbg_grant,
    input  logic beat_done,
    output logic force_dbg
);
    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (beat_done || !dbg_valid) begin
            cnt_d = '0;
        end else if (!dbg_grant && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign force_dbg = (cnt_q == LIMIT);
endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: MEM stage has priority, debug port can lock.
// Optional starvation guard enabled by LIGHT_DMEM_ARB_FAIRNESS_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
    input logic          clk,
    input logic          reset,
    dmem_arbiter_if.slave bus
);
    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT out of range 1..255");
    end

    logic              locked_q, locked_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              force_dbg;
    logic              dbg_grant;
    logic              beat_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;

`ifdef LIGHT_DMEM_ARB_FAIRNESS_EN
    dmem_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_cnt (
        .clk       (clk),
        .reset     (reset),
        .dbg_valid (bus.i_dbg_Valid),
        .dbg_grant (dbg_grant),
        .beat_done (beat_done),
        .force_dbg (force_dbg)
    );
`else
    assign force_dbg = 1'b0;
`endif

    always_comb begin
        dbg_grant = bus.i_dbg_Valid && (!bus.i_pipe_Req || locked_q || force_dbg);
        beat_done = dbg_grant;

        // A pipe store is suppressed while locked so a stalled store cannot land twice.
        if (dbg_grant) begin
            mem_addr = bus.i_dbg_Addr;
            mem_data = bus.i_dbg_WrData;
            mem_we   = bus.i_dbg_WrEn;
        end else begin
            mem_addr = bus.i_pipe_Addr;
            mem_data = bus.i_pipe_WrData;
            mem_we   = bus.i_pipe_Req && bus.i_pipe_WrEn && !locked_q;
        end

        locked_d   = beat_done ? bus.i_dbg_Lock : locked_q;
        rd_valid_d = beat_done && !bus.i_dbg_WrEn;
        rd_data_d  = rd_valid_d ? bus.i_mem_DataOut : rd_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            locked_q   <= locked_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.o_mem_Addr    = mem_addr;
    assign bus.o_mem_DataIn  = mem_data;
    assign bus.o_mem_WrEn    = mem_we;
    assign bus.o_pipe_RdData = bus.i_mem_DataOut;
    assign bus.o_pipe_Stall  = bus.i_pipe_Req && (dbg_grant || locked_q);
    assign bus.o_dbg_Ready   = dbg_grant;
    assign bus.o_dbg_RdValid = rd_valid_q;
    assign bus.o_dbg_RdData  = rd_data_q;
    assign bus.o_dbg_Locked  = locked_q;
endmodule
